// File: rtl/game_ctrl.sv
// Turn controller for a card-matching game: debounced-free button pulse generation plus a
// select/check/move FSM that drives compare (A), move (D) and turn-advance strobes.
module game_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       flip_btn,
  input  logic [3:0] card_sw,
  input  logic [2:0] n_sw,
  input  logic       go,
  input  logic       W,
  output logic [3:0] position_data,
  output logic [2:0] N,
  output logic       A,
  output logic       D,
  output logic       statecombo_next_turn,
  output logic [2:0] state,
  output logic       game_over
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSelect = 3'd1,
    StCheck  = 3'd2,
    StEval   = 3'd3,
    StMove   = 3'd4,
    StWinchk = 3'd5,
    StNext   = 3'd6,
    StOver   = 3'd7
  } state_e;

  // Reset asserts asynchronously but is released on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= '0;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  logic [SYNC_STAGES-1:0] start_sync_q, flip_sync_q;
  logic [SYNC_STAGES:0]   arm_q;
  logic                   start_prev_q, flip_prev_q, start_p_q, flip_p_q;

  // arm_q masks edges until the synchronizers hold real button levels, so a button held
  // across reset release is not mistaken for a press.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      start_sync_q <= '0;
      flip_sync_q  <= '0;
      arm_q        <= '0;
      start_prev_q <= 1'b0;
      flip_prev_q  <= 1'b0;
      start_p_q    <= 1'b0;
      flip_p_q     <= 1'b0;
    end else begin
      start_sync_q <= {start_sync_q[SYNC_STAGES-2:0], start_btn};
      flip_sync_q  <= {flip_sync_q[SYNC_STAGES-2:0], flip_btn};
      arm_q        <= {arm_q[SYNC_STAGES-1:0], 1'b1};
      start_prev_q <= start_sync_q[SYNC_STAGES-1];
      flip_prev_q  <= flip_sync_q[SYNC_STAGES-1];
      start_p_q    <= arm_q[SYNC_STAGES] & start_sync_q[SYNC_STAGES-1] & ~start_prev_q;
      flip_p_q     <= arm_q[SYNC_STAGES] & flip_sync_q[SYNC_STAGES-1] & ~flip_prev_q;
    end
  end

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    pos_q, pos_d;
  logic [2:0]    n_q, n_d;
  logic          a_q, a_d, d_q, d_d, nt_q, nt_d, over_q, over_d;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= StIdle;
      timer_q <= '0;
      pos_q   <= 4'd0;
      n_q     <= 3'd2;
      a_q     <= 1'b0;
      d_q     <= 1'b0;
      nt_q    <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pos_q   <= pos_d;
      n_q     <= n_d;
      a_q     <= a_d;
      d_q     <= d_d;
      nt_q    <= nt_d;
      over_q  <= over_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start_p_q) state_d = StSelect;
      StSelect: begin
        if (flip_p_q)                   state_d = StCheck;
        else if (timer_q == TimeoutLast) state_d = StNext;
      end
      StCheck:  state_d = StEval;
      StEval:   state_d = go ? StMove : StNext;
      StMove:   state_d = StWinchk;
      StWinchk: state_d = W ? StOver : StSelect;
      StNext:   state_d = StSelect;
      StOver:   if (start_p_q) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Strobes are decoded from the next state and registered, so they align with state.
  always_comb begin
    a_d     = (state_d == StCheck);
    d_d     = (state_d == StMove);
    nt_d    = (state_d == StNext);
    over_d  = (state_d == StOver);
    timer_d = (state_q == StSelect && state_d == StSelect) ? timer_q + 1'b1 : '0;
    pos_d   = pos_q;
    n_d     = n_q;
    if (state_q == StSelect && state_d == StCheck) pos_d = card_sw;
    if (state_q == StIdle && state_d == StSelect) begin
      if (n_sw < 3'd2)      n_d = 3'd2;
      else if (n_sw > 3'd4) n_d = 3'd4;
      else                  n_d = n_sw;
    end
  end

  assign position_data        = pos_q;
  assign N                    = n_q;
  assign A                    = a_q;
  assign D                    = d_q;
  assign statecombo_next_turn = nt_q;
  assign state                = state_q;
  assign game_over            = over_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Randomized scoreboard bench for game_ctrl: a turn-level timeline model predicts every state
// change with its cycle; a monitor pops and compares whenever the DUT state changes.
module tb_game_ctrl;
  localparam int unsigned S = 2;
  localparam int unsigned T = 8;
  localparam int MIdle = 0, MSelect = 1, MOver = 2;

  logic       clk = 1'b0;
  logic       rst, start_btn, flip_btn, go, W;
  logic [3:0] card_sw;
  logic [2:0] n_sw;
  logic [3:0] position_data;
  logic [2:0] N, state;
  logic       A, D, statecombo_next_turn, game_over;

  game_ctrl #(.SYNC_STAGES(S), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .flip_btn(flip_btn), .card_sw(card_sw),
    .n_sw(n_sw), .go(go), .W(W), .position_data(position_data), .N(N), .A(A), .D(D),
    .statecombo_next_turn(statecombo_next_turn), .state(state), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int         at;
    logic [2:0] st;
    logic       a, d, nt, ov;
    logic [3:0] pos;
    logic [2:0] n;
  } ev_t;

  ev_t        exp_q[$];
  int         n_total = 0, n_pass = 0;
  int         m_st, m_e;
  logic [3:0] m_pos;
  logic [2:0] m_n;
  bit         mon_en = 1'b0;
  logic [2:0] prev_st = 3'd0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic logic [2:0] clamp(input logic [2:0] v);
    int x = int'(v);
    return (x < 2) ? 3'd2 : (x > 4) ? 3'd4 : 3'(x);
  endfunction

  // Strobe and flag values follow from which state is entered.
  function automatic void expect_state(input int at, input logic [2:0] st);
    ev_t ev;
    ev.at = at; ev.st = st;
    ev.a = (st == 3'd2); ev.d = (st == 3'd4); ev.nt = (st == 3'd6); ev.ov = (st == 3'd7);
    ev.pos = m_pos; ev.n = m_n;
    exp_q.push_back(ev);
  endfunction

  // Idle SELECT lasts T cycles, then one NEXT cycle, then SELECT again.
  function automatic void model_timeouts(input int lim);
    while (m_st == MSelect && m_e + int'(T) <= lim) begin
      expect_state(m_e + int'(T), 3'd6);
      expect_state(m_e + int'(T) + 1, 3'd1);
      m_e += int'(T) + 1;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int k);
    model_timeouts(k);
    while (cyc < k) step();
  endtask

  task automatic monitor_loop();
    ev_t ev;
    forever begin
      @(negedge clk);
      if (mon_en && state !== prev_st) begin
        if (exp_q.size() == 0) begin
          check("spurious_transition", {29'd0, state}, {29'd0, prev_st});
        end else begin
          ev = exp_q.pop_front();
          check("transition", {cyc[15:0], state, A, D, statecombo_next_turn, game_over,
                               position_data, N},
                {ev.at[15:0], ev.st, ev.a, ev.d, ev.nt, ev.ov, ev.pos, ev.n});
        end
        prev_st = state;
      end
    end
  endtask

  // A raw rise after edge c becomes effective at edge c+S+2.
  task automatic do_start(input logic [2:0] nsw);
    int c, f;
    c = cyc; f = c + int'(S) + 2;
    model_timeouts(f - 1);
    if (m_st == MIdle) begin
      m_n = clamp(nsw); m_st = MSelect; m_e = f; expect_state(f, 3'd1);
    end else if (m_st == MOver) begin
      m_st = MIdle; expect_state(f, 3'd0);
    end
    n_sw = nsw; start_btn = 1'b1;
    wait_until(c + $urandom_range(1, 3));
    start_btn = 1'b0;
    wait_until(c + 2 * int'(S) + 4);
  endtask

  task automatic do_flip(input logic [3:0] card, input bit gv, input bit wv);
    int c, f;
    bit acc;
    c = cyc; f = c + int'(S) + 2;
    model_timeouts(f - 1);
    acc = (m_st == MSelect) && (f - 1 >= m_e);
    if (acc) begin
      m_pos = card;
      expect_state(f, 3'd2);
      expect_state(f + 1, 3'd3);
      if (gv) begin
        expect_state(f + 2, 3'd4);
        expect_state(f + 3, 3'd5);
        if (wv) begin m_st = MOver; expect_state(f + 4, 3'd7); end
        else begin m_e = f + 4; expect_state(f + 4, 3'd1); end
      end else begin
        expect_state(f + 2, 3'd6);
        m_e = f + 3; expect_state(f + 3, 3'd1);
      end
    end
    card_sw = card; flip_btn = 1'b1;
    wait_until(c + $urandom_range(1, 3));
    flip_btn = 1'b0;
    if (acc) begin
      wait_until(f + 1); go = gv;
      wait_until(f + 2); go = 1'($urandom);
      if (gv) begin
        wait_until(f + 3); W = wv;
        wait_until(f + 4); W = 1'($urandom);
      end
    end
    wait_until(c + 2 * int'(S) + 4);
  endtask

  task automatic apply_reset(input bit hold);
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    check("reset_outputs",
          {state, position_data, N, A, D, statecombo_next_turn, game_over},
          {3'd0, 4'd0, 3'd2, 4'b0000});
    exp_q.delete();
    m_st = MIdle; m_pos = 4'd0; m_n = 3'd2;
    start_btn = hold; flip_btn = hold;
    n_sw = 3'd3;
    wait_until(cyc + 3);
    rst = 1'b1;
    prev_st = 3'd0;
    mon_en = 1'b1;
    wait_until(cyc + 15);
    if (hold) begin
      check("held_btn_no_pulse", {29'd0, state}, 32'd0);
      start_btn = 1'b0; flip_btn = 1'b0;
      wait_until(cyc + int'(S) + 3);
    end
  endtask

  initial begin
    int k, c, f;
    rst = 1'b0; start_btn = 1'b0; flip_btn = 1'b0; go = 1'b0; W = 1'b0;
    card_sw = 4'd0; n_sw = 3'd0;
    m_st = MIdle; m_e = 0; m_pos = 4'd0; m_n = 3'd2;
    fork monitor_loop(); join_none
    repeat (3) step();
    apply_reset(1'b0);

    // player-count clamping
    do_start(3'd3); check("n_clamp_3", {29'd0, N}, 32'd3);
    apply_reset(1'b0);
    do_start(3'd7); check("n_clamp_7", {29'd0, N}, 32'd4);
    apply_reset(1'b0);
    do_start(3'd0); check("n_clamp_0", {29'd0, N}, 32'd2);

    do_flip(4'd9, 1'b1, 1'b0);
    check("pos_after_match", {28'd0, position_data}, 32'd9);
    check("state_after_match", {29'd0, state}, 32'd1);
    do_flip(4'd5, 1'b0, 1'b0);

    // idle SELECT times out, then a flip lands on the last SELECT cycle
    k = m_e + int'(T) + 3;
    wait_until(k);
    check("state_after_timeout", {29'd0, state}, 32'd1);
    wait_until(m_e + int'(T) - int'(S) - 2);
    do_flip(4'd6, 1'b0, 1'b0);

    do_flip(4'd11, 1'b1, 1'b1);
    check("game_over_set", {31'd0, game_over}, 32'd1);
    do_flip(4'd3, 1'b1, 1'b0);
    check("pos_held_in_over", {28'd0, position_data}, 32'd11);
    do_start(3'd5);
    check("game_over_clear", {31'd0, game_over}, 32'd0);
    do_start(3'd6);

    for (int i = 0; i < 80; i++) begin
      if (m_st == MSelect) begin
        if ($urandom_range(0, 4) == 0) do_start(3'($urandom_range(0, 7)));
        wait_until(cyc + $urandom_range(0, T + 3));
        do_flip(4'($urandom_range(0, 15)), $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3);
      end else begin
        if (m_st == MOver && $urandom_range(0, 1) == 1) do_flip(4'($urandom_range(0, 15)), 1'b1, 1'b0);
        do_start(3'($urandom_range(0, 7)));
      end
    end

    // reset while in MOVE, with both buttons held across release
    apply_reset(1'b0);
    do_start(3'd2);
    c = cyc; f = c + int'(S) + 2;
    m_pos = 4'hC;
    expect_state(f, 3'd2); expect_state(f + 1, 3'd3); expect_state(f + 2, 3'd4);
    m_st = MIdle;
    card_sw = 4'hC; flip_btn = 1'b1;
    wait_until(c + 1); flip_btn = 1'b0;
    wait_until(f + 1); go = 1'b1;
    wait_until(f + 2);
    #5;
    check("queue_drained_at_move", exp_q.size(), 32'd0);
    apply_reset(1'b1);

    do_start(3'd3);
    do_flip(4'd1, 1'b1, 1'b1);
    do_start(3'd1);
    wait_until(cyc + 10);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on each raw button input (min 2).
REQ-002 Parameter TIMEOUT_CYC, default 50_000_000: cycles allowed in SELECT before the turn is forfeited (min 2).
REQ-003 clk  in  1  single system clock; all flops on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset; asserts immediately, releases synchronously to clk.
REQ-005 start_btn  in  1  raw, unsynchronized start/restart button.
REQ-006 flip_btn  in  1  raw, unsynchronized card-flip button.
REQ-007 card_sw  in  4  card index chosen by the current player.
REQ-008 n_sw  in  3  requested player count.
REQ-009 go  in  1  match result from the datapath; valid the cycle after A.
REQ-010 W  in  1  win flag from the datapath; valid the cycle after D.
REQ-011 position_data  out  4  registered card index driven to the datapath.
REQ-012 N  out  3  latched, clamped player count.
REQ-013 A  out  1  one-cycle compare strobe.
REQ-014 D  out  1  one-cycle move strobe.
REQ-015 statecombo_next_turn  out  1  one-cycle turn-advance strobe.
REQ-016 state  out  3  current FSM state encoding.
REQ-017 game_over  out  1  high while in OVER.

Function
REQ-018 Each button SHALL pass through SYNC_STAGES flops, then a rising-edge detector yielding a one-cycle pulse (start_p, flip_p); a held button SHALL yield exactly one pulse.
REQ-019 States and encodings SHALL be IDLE=0, SELECT=1, CHECK=2, EVAL=3, MOVE=4, WINCHK=5, NEXT=6, OVER=7.
REQ-020 IDLE: on start_p, latch N = 2 if n_sw<2, 4 if n_sw>4, else n_sw; go to SELECT.
REQ-021 SELECT: on flip_p, latch card_sw into position_data and go to CHECK.
REQ-022 SELECT: a timeout counter, cleared on every SELECT entry, SHALL increment each SELECT cycle; when it reaches TIMEOUT_CYC-1 with no flip_p, go to NEXT.
REQ-023 flip_p and timeout in the same cycle: flip_p SHALL win (go to CHECK).
REQ-024 CHECK: A=1 for exactly this cycle; go to EVAL.
REQ-025 EVAL: sample go; go=1 -> MOVE, go=0 -> NEXT.
REQ-026 MOVE: D=1 for exactly this cycle; go to WINCHK.
REQ-027 WINCHK: sample W; W=1 -> OVER, W=0 -> SELECT (same player continues).
REQ-028 NEXT: statecombo_next_turn=1 for exactly this cycle; go to SELECT.
REQ-029 OVER: game_over=1; position_data and N SHALL hold; on start_p go to IDLE.
REQ-030 start_p outside IDLE/OVER and flip_p outside SELECT SHALL be ignored, and no pulse SHALL be queued.
REQ-031 A, D and statecombo_next_turn SHALL be mutually exclusive and registered (glitch-free).
REQ-032 Latency: raw flip_btn rise to A high SHALL be SYNC_STAGES+2 cycles.

Reset
REQ-033 While rst=0: state=IDLE, position_data=0, N=2, A=D=statecombo_next_turn=0, game_over=0, timeout counter=0, synchronizer and edge-detector flops=0.
REQ-034 Reset asserted mid-operation (any state) SHALL return to IDLE immediately; no strobe SHALL be emitted on release.
REQ-035 A button held through reset release SHALL NOT generate a pulse.

Verification
REQ-036 Reset, start_btn high with n_sw=3 -> SELECT, N=3; repeat with n_sw=7 -> N=4; n_sw=0 -> N=2.
REQ-037 In SELECT, card_sw=9, flip_btn pulse, go=1 two cycles later, W=0 -> position_data=9, A then D one cycle each, back to SELECT, no statecombo_next_turn.
REQ-038 Flip with go=0 -> A pulse, then statecombo_next_turn pulse exactly 2 cycles after A, state returns to 1.
REQ-039 TIMEOUT_CYC=8, no flip -> statecombo_next_turn after 8 SELECT cycles; flip on cycle 8 -> CHECK, no strobe.
REQ-040 Match with W=1 -> state=7, game_over=1; flip ignored; start_btn -> IDLE, game_over=0.
REQ-041 Assert rst during MOVE -> all outputs at reset values in the same cycle; flip_btn held across release -> no A.
